// File: rtl/adder_pkg.sv
// Shared constants and types for the adder library.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 16;

    localparam logic [ADDER_WIDTH:1] SUM_RST = '0;

    typedef struct packed {
        logic                   cout;
        logic [ADDER_WIDTH:1]   sum;
    } add_result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the ripple stage of bit16_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bit16_adder.sv
// Registered 16-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
module bit16_adder
    import adder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDER_WIDTH:1]   a,
    input  logic [ADDER_WIDTH:1]   b,
    input  logic                   cin,
    output logic [ADDER_WIDTH:1]   sum,
    output logic                   cout
);

    logic [ADDER_WIDTH:0] carry;
    logic [ADDER_WIDTH:1] sum_comb;
    add_result_t          res_d;
    logic [ADDER_WIDTH:1] sum_q;
    logic                 cout_q;

    assign carry[0] = cin;

    // carry[i] is the carry out of stage i; bit numbering starts at 1.
    for (genvar i = 1; i <= ADDER_WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i-1]),
            .sum  (sum_comb[i]),
            .cout (carry[i])
        );
    end

    always_comb begin
        res_d.sum  = sum_comb;
        res_d.cout = carry[ADDER_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= SUM_RST;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= res_d.sum;
            cout_q <= res_d.cout;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit16_adder.sv
// Self-checking bench for bit16_adder: directed vector table plus random back-to-back traffic.
module tb_bit16_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [16:1] a = '0;
    logic [16:1] b = '0;
    logic        cin = 1'b0;
    logic [16:1] sum;
    logic        cout;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [16:0] exp_q[$];
    vec_t        vecs[7];

    bit16_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got cout/sum=%h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [16:0] exp);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        exp_q.push_back(exp);
    endtask

    task automatic collect(input string name);
        logic [16:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_noexp"}, {cout, sum}, 17'h1_FFFF ^ {cout, sum});
        end else begin
            exp = exp_q.pop_front();
            check(name, {cout, sum}, exp);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] ref_sum;

        vecs[0] = '{16'h0820, 16'h1083, 1'b1, 16'h18A4, 1'b0};
        vecs[1] = '{16'h2F18, 16'h3830, 1'b0, 16'h6748, 1'b0};
        vecs[2] = '{16'hC1E0, 16'h641F, 1'b0, 16'h25FF, 1'b1};
        vecs[3] = '{16'h3CEE, 16'h7FE0, 1'b1, 16'hBCCF, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        // Reset held with arbitrary inputs while the clock runs.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            @(posedge clk);
            #1 check("reset_hold", {cout, sum}, 17'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
            collect($sformatf("vec%0d", i));
        end

        // Mid-stream reset clears a nonzero result before any clock edge.
        drive(16'hC1E0, 16'h641F, 1'b0, 17'h1_25FF);
        collect("pre_async_rst");
        #2 rst_n = 1'b0;
        #1 check("async_rst_clear", {cout, sum}, 17'h0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(posedge clk);
        #1 check("async_rst_hold", {cout, sum}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
        collect("first_after_rst");

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            drive(ra, rb, rc, ref_sum);
            collect("random");
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 check("rand_rst_clear", {cout, sum}, 17'h0);
                @(negedge clk);
                a = 16'($urandom); b = 16'($urandom); cin = 1'b1;
                @(posedge clk);
                #1 check("rand_rst_hold", {cout, sum}, 17'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
